// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge: FSM states and the
// registered response record.
package apb_pkg;

    localparam int         APB_DATA_MAX     = 32;
    localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    // Sized for the widest legal bus; narrower builds use the low bits.
    typedef struct packed {
        logic [APB_DATA_MAX-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response ports plus the APB4 requester bus, bundled for the bridge.
// The master modport is the bridge side; slave is the command source and the APB peripheral.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_BITS   = 2
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic                    cmd_write;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [DATA_WIDTH/8-1:0] cmd_strb;
    logic [2:0]              cmd_prot;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [2:0]              PPROT;
    logic [2**SEL_BITS-1:0]  PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low. It flags the last allowed wait cycle
// so the bridge can abort on that edge.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] r_count;

            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge PCLK) begin
                if (PRESET || clear) begin
                    r_count <= '0;
                end else if (count_en) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // The bridge leaves ACCESS on this edge, so the counter never wraps.
            assign expired = count_en && (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester. It takes one valid/ready command at a time, runs SETUP/ACCESS
// with a one-hot PSEL decode and a bounded PREADY wait, then returns a response.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_BITS       = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 PCLK,
    input logic                 PRESET,
    apb_master_bridge_if.master bus
);

    localparam int NSLV   = 2**SEL_BITS;
    localparam int STRB_W = DATA_WIDTH / 8;

    apb_state_e            r_state;
    apb_state_e            w_next_state;
    logic                  r_cmd_ready;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [2:0]            r_pprot;
    logic [NSLV-1:0]       r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    apb_rsp_t              r_rsp;

    logic                  w_cmd_hs;
    logic                  w_rsp_hs;
    logic                  w_expired;
    logic [NSLV-1:0]       w_psel_dec;

    assign w_cmd_hs   = bus.cmd_valid && r_cmd_ready;
    assign w_rsp_hs   = (r_state == RESP) && bus.rsp_ready;
    assign w_psel_dec = NSLV'(1) << bus.cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clear   (r_state == SETUP),
        .count_en((r_state == ACCESS) && !bus.PREADY),
        .expired (w_expired)
    );

    // NOTE: the default before the case keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_cmd_hs) w_next_state = SETUP;
            SETUP:   w_next_state = ACCESS;
            ACCESS:  if (bus.PREADY || w_expired) w_next_state = RESP;
            RESP:    if (w_rsp_hs) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_paddr     <= '0;
            r_pprot     <= APB_PROT_DEFAULT;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp       <= '0;
        end else begin
            r_state     <= w_next_state;
            // Registered ready: low during reset, high the cycle after release.
            r_cmd_ready <= (w_next_state == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        r_paddr  <= bus.cmd_addr;
                        r_pprot  <= bus.cmd_prot;
                        r_pwrite <= bus.cmd_write;
                        r_pwdata <= bus.cmd_wdata;
                        r_pstrb  <= bus.cmd_write ? bus.cmd_strb : '0;
                        r_psel   <= w_psel_dec;
                    end
                end
                SETUP: r_penable <= 1'b1;
                ACCESS: begin
                    if (bus.PREADY) begin
                        r_psel          <= '0;
                        r_penable       <= 1'b0;
                        r_rsp.rdata     <= r_pwrite ? '0 : APB_DATA_MAX'(bus.PRDATA);
                        r_rsp.err       <= bus.PSLVERR;
                        r_rsp.timeout   <= 1'b0;
                    end else if (w_expired) begin
                        r_psel          <= '0;
                        r_penable       <= 1'b0;
                        r_rsp.rdata     <= '0;
                        r_rsp.err       <= 1'b1;
                        r_rsp.timeout   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.rsp_rdata   = r_rsp.rdata[DATA_WIDTH-1:0];
    assign bus.rsp_err     = r_rsp.err;
    assign bus.rsp_timeout = r_rsp.timeout;
    assign bus.PADDR       = r_paddr;
    assign bus.PPROT       = r_pprot;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PWDATA      = r_pwdata;
    assign bus.PSTRB       = r_pstrb;

endmodule
